frame_buffer_manager: RTL and testbench
=======================================

# frame_buffer_manager

Parametrised successor to the top-level two-page memory flip logic: owns the allocation of N frame buffers in the display memory between the SPI loader (writer) and the display driver (reader). Hands the writer a free buffer and promotes completed frames to the reader only at frame boundaries. Supports 2–4 buffers with newest-frame or in-order presentation, and exposes frame/drop/repeat statistics. Sits between `spi_controller` (`ready`/`loaded`), `display_driver` (`frame_complete`) and `display_memory` (buffer select lines).

## Interface
- `BUFFERS`, 2 — number of frame buffers; legal range 2..4.
- `MODE_LATEST`, 1 — 1: present the newest pending frame and drop older ones; 0: present pending frames in load order.
- `COUNT_WIDTH`, 16 — width of the statistics counters.
- Derived: `IDXW` = max(1, clog2(BUFFERS)).

Ports:
- `clk` in 1 — single clock; all logic on its rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `frame_complete` in 1 — one-cycle pulse from the driver at end of frame.
- `loaded` in 1 — one-cycle pulse from the loader: the frame in `wbuf` is fully written.
- `ready` out 1 — `wbuf` is allocated to the writer and may be written.
- `wbuf` out IDXW — buffer index the writer targets.
- `rbuf` out IDXW — buffer index the driver reads.
- `valid` out 1 — at least one loaded frame has been presented since reset.
- `pending` out IDXW+1 — number of buffers in the PENDING state.
- `frames_shown` out COUNT_WIDTH — swaps performed.
- `frames_dropped` out COUNT_WIDTH — pending frames discarded in latest mode.
- `frames_repeated` out COUNT_WIDTH — `frame_complete` events with nothing pending.
- `proto_err` out 1 — sticky; set by `loaded` while `ready`=0.

## Operation
- Each buffer is in one state: FREE, WRITING, PENDING or SHOWING. Exactly one buffer is SHOWING. At most one buffer is WRITING.
- Reset values:
  - buffer 0 SHOWING, buffer 1 WRITING, all others FREE;
  - `rbuf`=0, `wbuf`=1, `ready`=1, `valid`=0, `pending`=0;
  - all counters 0, `proto_err`=0.
- `loaded` with `ready`=1:
  - the WRITING buffer becomes PENDING and is appended to the pending queue;
  - the lowest-index FREE buffer becomes WRITING (`wbuf` updates, `ready` stays 1);
  - if no FREE buffer exists, `ready`=0.
- `loaded` with `ready`=0: ignored apart from setting `proto_err`.
- `frame_complete` with ≥1 pending frame:
  - the selected pending buffer becomes SHOWING: the newest if `MODE_LATEST`=1, otherwise the queue head;
  - the previous SHOWING buffer becomes FREE;
  - in latest mode, all other pending buffers become FREE, and `frames_dropped` increases by their count;
  - `frames_shown`+1 and `valid`=1.
- `frame_complete` with nothing pending: `rbuf` is unchanged and `frames_repeated`+1.
- Whenever `ready`=0 and a buffer becomes FREE, the lowest-index FREE buffer becomes WRITING and `ready`=1.
- Simultaneous `loaded` and `frame_complete`: the frame being loaded counts as pending for that same `frame_complete`, so it can be presented immediately. Allocation for the writer happens after the swap, so a just-freed buffer is eligible.
- With `BUFFERS`=2 the block reduces to the flip behaviour: `wbuf` = ~`rbuf` whenever `ready`=1.
- Counters saturate at all-ones.

## Timing
- All outputs are registered. An event on cycle N is visible on the outputs in cycle N+1; there is no further latency.
- `rbuf` changes only in the cycle after a `frame_complete`, never at any other time.
- `wbuf` changes only in the cycle after `loaded` or after a reallocation. While `ready`=1, `wbuf` is stable until `loaded`.
- `rst_n` asserted mid-frame: all state returns to reset values immediately and asynchronously. Release is synchronised internally, with two flops before the first state update.
- `loaded` and `frame_complete` are single-cycle pulses. Back-to-back pulses on consecutive cycles are legal and must each be processed.

## Structure
- Shared package `display_pkg`:
  - `buf_state_t` enum (FREE/WRITING/PENDING/SHOWING);
  - an `idx_width()` function;
  - the `BUFFERS` range constants.
- Sub-module `buffer_queue`: a FIFO of buffer indices, depth BUFFERS-1, supporting push, pop-head, pop-tail and flush. It provides the ordering for both modes.

## Test plan
- Reset, BUFFERS=2: check `rbuf`=0, `wbuf`=1, `ready`=1. Then `loaded` gives `ready`=0; then `frame_complete` gives `rbuf`=1, `wbuf`=0, `ready`=1, `frames_shown`=1, `valid`=1.
- BUFFERS=3, MODE_LATEST=1: three `loaded` (the third with `ready`=0), then `frame_complete`. Expect `rbuf`=2, `frames_dropped`=1, `proto_err`=1.
- BUFFERS=4, MODE_LATEST=0: loads into buffers 1, 2, 3, then three `frame_complete`. Expect `rbuf` sequence 1, 2, 3 and `frames_dropped`=0.
- `frame_complete` ×5 with nothing loaded: `rbuf`=0, `frames_repeated`=5, `valid`=0.
- Same-cycle `loaded`+`frame_complete`, BUFFERS=2: next cycle `rbuf`=1, `wbuf`=0, `ready`=1.
- `rst_n` low mid-sequence with `pending`=2: outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the display memory subsystem.
//   buf_state_t   - ownership state of one frame buffer
//   idx_width()   - width of a buffer index for a given buffer count
//   BUFFERS_MIN/MAX - legal range of the frame buffer count
package display_pkg;

  localparam int BUFFERS_MIN = 2;
  localparam int BUFFERS_MAX = 4;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_PENDING = 2'd2,
    BUF_SHOWING = 2'd3
  } buf_state_t;

  // A single buffer index is never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/buffer_queue.sv
// buffer_queue
// FIFO of buffer indices holding the load order of pending frames.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   push, push_idx      - append an index at the tail
//   pop_head / pop_tail - remove the oldest / newest entry
//   flush               - discard every entry
//   head, tail          - oldest / newest entry (undefined when empty)
//   count               - number of entries held
// Pops and flush are applied before a same-cycle push, so a full queue
// can pop and push in the same cycle.
module buffer_queue #(
  parameter  int DEPTH = 1,
  parameter  int IDXW  = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [IDXW-1:0] push_idx,
  input  logic            pop_head,
  input  logic            pop_tail,
  input  logic            flush,
  output logic [IDXW-1:0] head,
  output logic [IDXW-1:0] tail,
  output logic [CW-1:0]   count
);

  logic [IDXW-1:0] entries   [DEPTH];
  logic [IDXW-1:0] entries_n [DEPTH];
  logic [CW-1:0]   count_n;

  always_comb begin
    entries_n = entries;
    count_n   = count;
    if (flush) begin
      count_n = '0;
    end else begin
      if (pop_head && (count_n != '0)) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          entries_n[i] = entries[i+1];
        end
        count_n = count_n - CW'(1);
      end
      if (pop_tail && (count_n != '0)) begin
        count_n = count_n - CW'(1);
      end
    end
    if (push && (count_n < CW'(DEPTH))) begin
      entries_n[count_n] = push_idx;
      count_n            = count_n + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      count   <= count_n;
      entries <= entries_n;
    end
  end

  assign head = entries[0];
  assign tail = (count == '0) ? entries[0] : entries[count - CW'(1)];

endmodule

// File: rtl/frame_buffer_manager.sv
// frame_buffer_manager
// Allocates BUFFERS frame buffers between the SPI loader (writer) and the
// display driver (reader), promoting finished frames only at frame ends.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   frame_complete    - end-of-frame pulse from the display driver
//   loaded            - the frame in wbuf is fully written
//   ready, wbuf       - writer has buffer wbuf allocated
//   rbuf              - buffer the driver reads
//   valid             - a loaded frame has been shown since reset
//   pending           - number of frames waiting to be shown
//   frames_shown/dropped/repeated - saturating statistics
//   proto_err         - sticky: loaded seen while ready was low
module frame_buffer_manager
  import display_pkg::*;
#(
  parameter  int BUFFERS     = 2,
  parameter  int MODE_LATEST = 1,
  parameter  int COUNT_WIDTH = 16,
  localparam int IDXW        = idx_width(BUFFERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_complete,
  input  logic                   loaded,
  output logic                   ready,
  output logic [IDXW-1:0]        wbuf,
  output logic [IDXW-1:0]        rbuf,
  output logic                   valid,
  output logic [IDXW:0]          pending,
  output logic [COUNT_WIDTH-1:0] frames_shown,
  output logic [COUNT_WIDTH-1:0] frames_dropped,
  output logic [COUNT_WIDTH-1:0] frames_repeated,
  output logic                   proto_err
);

  localparam int QDEPTH = BUFFERS - 1;
  localparam int QCW    = $clog2(QDEPTH + 1);
  localparam bit LATEST = (MODE_LATEST != 0);

  // Reset release is retimed through two flops; state only advances once
  // the second flop is set, so events right after release are ignored.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  buf_state_t       st   [BUFFERS];
  buf_state_t       st_n [BUFFERS];
  logic [IDXW-1:0]  rbuf_n;
  logic [IDXW-1:0]  wbuf_n;
  logic             ready_n;
  logic [IDXW:0]    pend_n;
  logic [IDXW-1:0]  sel;
  logic [IDXW-1:0]  q_head;
  logic [IDXW-1:0]  q_tail;
  logic [QCW-1:0]   q_count;
  logic             q_push;
  logic             q_pop_head;
  logic             q_flush;
  logic             do_load;
  logic             do_fc;
  logic             swap;
  logic [IDXW:0]    eff_pend;

  // The frame loaded this cycle counts as pending for a same-cycle swap.
  assign do_load  = run & loaded & ready;
  assign do_fc    = run & frame_complete;
  assign eff_pend = (IDXW+1)'(q_count) + (IDXW+1)'(do_load);
  assign swap     = do_fc && (eff_pend != '0);

  // Pick the frame to present: the newest in latest mode, else the oldest.
  always_comb begin
    if (LATEST) begin
      sel = do_load ? wbuf : q_tail;
    end else begin
      sel = (q_count != '0) ? q_head : wbuf;
    end
  end

  // A frame that is both loaded and shown in the same cycle never needs
  // to enter the queue; latest mode empties the queue on every swap.
  always_comb begin
    q_flush    = swap && LATEST;
    q_pop_head = swap && !LATEST && (q_count != '0);
    q_push     = do_load && !(swap && (LATEST || (q_count == '0)));
  end

  buffer_queue #(
    .DEPTH (QDEPTH),
    .IDXW  (IDXW)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (q_push),
    .push_idx (wbuf),
    .pop_head (q_pop_head),
    .pop_tail (1'b0),
    .flush    (q_flush),
    .head     (q_head),
    .tail     (q_tail),
    .count    (q_count)
  );

  // Buffer ownership update: load, then swap, then writer allocation, so
  // a buffer freed by the swap is immediately eligible for the writer.
  always_comb begin
    for (int i = 0; i < BUFFERS; i++) begin
      st_n[i] = st[i];
    end
    rbuf_n  = rbuf;
    wbuf_n  = wbuf;
    ready_n = ready;

    if (do_load) begin
      st_n[wbuf] = BUF_PENDING;
    end

    if (swap) begin
      st_n[rbuf] = BUF_FREE;
      if (LATEST) begin
        for (int i = 0; i < BUFFERS; i++) begin
          if (st_n[i] == BUF_PENDING) begin
            st_n[i] = BUF_FREE;
          end
        end
      end
      st_n[sel] = BUF_SHOWING;
      rbuf_n    = sel;
    end

    if (do_load || !ready) begin
      ready_n = 1'b0;
      for (int i = BUFFERS - 1; i >= 0; i--) begin
        if (st_n[i] == BUF_FREE) begin
          wbuf_n  = IDXW'(i);
          ready_n = 1'b1;
        end
      end
      if (ready_n) begin
        st_n[wbuf_n] = BUF_WRITING;
      end
    end

    pend_n = '0;
    for (int i = 0; i < BUFFERS; i++) begin
      if (st_n[i] == BUF_PENDING) begin
        pend_n = pend_n + (IDXW+1)'(1);
      end
    end
  end

  function automatic logic [COUNT_WIDTH-1:0] sat_add(
    input logic [COUNT_WIDTH-1:0] a,
    input logic [IDXW:0]          b
  );
    logic [COUNT_WIDTH:0] s;
    s = {1'b0, a} + (COUNT_WIDTH+1)'(b);
    return s[COUNT_WIDTH] ? '1 : s[COUNT_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUFFERS; i++) begin
        st[i] <= (i == 0) ? BUF_SHOWING : ((i == 1) ? BUF_WRITING : BUF_FREE);
      end
      rbuf            <= '0;
      wbuf            <= IDXW'(1);
      ready           <= 1'b1;
      valid           <= 1'b0;
      pending         <= '0;
      frames_shown    <= '0;
      frames_dropped  <= '0;
      frames_repeated <= '0;
      proto_err       <= 1'b0;
    end else if (run) begin
      st      <= st_n;
      rbuf    <= rbuf_n;
      wbuf    <= wbuf_n;
      ready   <= ready_n;
      pending <= pend_n;
      if (swap) begin
        frames_shown <= sat_add(frames_shown, (IDXW+1)'(1));
        valid        <= 1'b1;
      end
      if (swap && LATEST) begin
        frames_dropped <= sat_add(frames_dropped, eff_pend - (IDXW+1)'(1));
      end
      if (do_fc && !swap) begin
        frames_repeated <= sat_add(frames_repeated, (IDXW+1)'(1));
      end
      if (loaded && !ready) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb_frame_buffer_manager
// Three instances run side by side: two buffers / latest, three buffers /
// latest, four buffers / in-order. A buffer-ownership model with a plain
// load-order list predicts every output; directed sequences pin the model
// with literal values, then random pulses exercise the rest.
module tb_frame_buffer_manager;

  localparam int NB  [3] = '{2, 3, 4};
  localparam int LAT [3] = '{1, 1, 0};
  localparam int MF = 0, MW = 1, MP = 2, MS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] loaded_v = '0;
  logic [2:0] fc_v = '0;

  logic [2:0] ready_v, valid_v, err_v;
  logic [0:0] rbuf0, wbuf0;
  logic [1:0] rbuf1, wbuf1, rbuf2, wbuf2;
  logic [1:0] pend0;
  logic [2:0] pend1, pend2;
  logic [15:0] shown_a [3];
  logic [15:0] drop_a  [3];
  logic [15:0] rep_a   [3];

  int aR[3], aW[3], aP[3];

  int  mst   [3][4];
  int  mq    [3][4];
  int  mqn   [3];
  int  mr    [3], mw[3];
  bit  mready[3], mvalid[3], merr[3];
  int  mshown[3], mdrop[3], mrep[3];

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  frame_buffer_manager #(.BUFFERS(2), .MODE_LATEST(1), .COUNT_WIDTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .frame_complete(fc_v[0]), .loaded(loaded_v[0]),
    .ready(ready_v[0]), .wbuf(wbuf0), .rbuf(rbuf0), .valid(valid_v[0]),
    .pending(pend0), .frames_shown(shown_a[0]), .frames_dropped(drop_a[0]),
    .frames_repeated(rep_a[0]), .proto_err(err_v[0]));

  frame_buffer_manager #(.BUFFERS(3), .MODE_LATEST(1), .COUNT_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .frame_complete(fc_v[1]), .loaded(loaded_v[1]),
    .ready(ready_v[1]), .wbuf(wbuf1), .rbuf(rbuf1), .valid(valid_v[1]),
    .pending(pend1), .frames_shown(shown_a[1]), .frames_dropped(drop_a[1]),
    .frames_repeated(rep_a[1]), .proto_err(err_v[1]));

  frame_buffer_manager #(.BUFFERS(4), .MODE_LATEST(0), .COUNT_WIDTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .frame_complete(fc_v[2]), .loaded(loaded_v[2]),
    .ready(ready_v[2]), .wbuf(wbuf2), .rbuf(rbuf2), .valid(valid_v[2]),
    .pending(pend2), .frames_shown(shown_a[2]), .frames_dropped(drop_a[2]),
    .frames_repeated(rep_a[2]), .proto_err(err_v[2]));

  always_comb begin
    aR[0] = int'(rbuf0); aW[0] = int'(wbuf0); aP[0] = int'(pend0);
    aR[1] = int'(rbuf1); aW[1] = int'(wbuf1); aP[1] = int'(pend1);
    aR[2] = int'(rbuf2); aW[2] = int'(wbuf2); aP[2] = int'(pend2);
  end

  function automatic void checkValue(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int satInc(input int v, input int d);
    return (v + d > 65535) ? 65535 : v + d;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) mst[k][i] = MF;
      mst[k][0] = MS;
      mst[k][1] = MW;
      mqn[k] = 0;
      mr[k] = 0;
      mw[k] = 1;
      mready[k] = 1'b1;
      mvalid[k] = 1'b0;
      merr[k] = 1'b0;
      mshown[k] = 0;
      mdrop[k] = 0;
      mrep[k] = 0;
    end
  endfunction

  // One clock of the buffer ownership rules for instance k.
  function automatic void modelStep(input int k, input bit ld, input bit fc);
    bit doLoad;
    bit found;
    int sel;
    if (ld && !mready[k]) merr[k] = 1'b1;
    doLoad = ld && mready[k];
    if (doLoad) begin
      mst[k][mw[k]] = MP;
      mq[k][mqn[k]] = mw[k];
      mqn[k]++;
    end
    if (fc) begin
      if (mqn[k] == 0) begin
        mrep[k] = satInc(mrep[k], 1);
      end else begin
        if (LAT[k] != 0) begin
          sel = mq[k][mqn[k]-1];
          mdrop[k] = satInc(mdrop[k], mqn[k] - 1);
          for (int i = 0; i < mqn[k]; i++) mst[k][mq[k][i]] = MF;
          mqn[k] = 0;
        end else begin
          sel = mq[k][0];
          for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
          mqn[k]--;
        end
        mst[k][mr[k]] = MF;
        mst[k][sel] = MS;
        mr[k] = sel;
        mshown[k] = satInc(mshown[k], 1);
        mvalid[k] = 1'b1;
      end
    end
    if (doLoad || !mready[k]) begin
      found = 1'b0;
      for (int i = 0; i < NB[k]; i++) begin
        if (!found && mst[k][i] == MF) begin
          found = 1'b1;
          mw[k] = i;
          mst[k][i] = MW;
        end
      end
      mready[k] = found;
    end
  endfunction

  function automatic int modelPending(input int k);
    int n = 0;
    for (int i = 0; i < NB[k]; i++) if (mst[k][i] == MP) n++;
    return n;
  endfunction

  task automatic checkOutput(input int k);
    checkValue($sformatf("u%0d.rbuf", k), aR[k], mr[k]);
    checkValue($sformatf("u%0d.ready", k), int'(ready_v[k]), int'(mready[k]));
    if (mready[k]) checkValue($sformatf("u%0d.wbuf", k), aW[k], mw[k]);
    checkValue($sformatf("u%0d.valid", k), int'(valid_v[k]), int'(mvalid[k]));
    checkValue($sformatf("u%0d.pending", k), aP[k], modelPending(k));
    checkValue($sformatf("u%0d.shown", k), int'(shown_a[k]), mshown[k]);
    checkValue($sformatf("u%0d.dropped", k), int'(drop_a[k]), mdrop[k]);
    checkValue($sformatf("u%0d.repeated", k), int'(rep_a[k]), mrep[k]);
    checkValue($sformatf("u%0d.proto_err", k), int'(err_v[k]), int'(merr[k]));
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 3; k++) checkOutput(k);
    end
  end

  // Drive one cycle of pulses; the model advances just after the edge.
  task automatic applyStimulus(input logic [2:0] ld, input logic [2:0] fc);
    @(negedge clk);
    loaded_v = ld;
    fc_v = fc;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) modelStep(k, ld[k], fc[k]);
    loaded_v = '0;
    fc_v = '0;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 3'b000);
  endtask

  initial begin
    modelReset();
    checkEn = 1'b1;
    releaseReset();

    $display("[TB] reset values");
    checkValue("lit.u0.rbuf", aR[0], 0);
    checkValue("lit.u0.wbuf", aW[0], 1);
    checkValue("lit.u0.ready", int'(ready_v[0]), 1);
    checkValue("lit.u2.wbuf", aW[2], 1);

    $display("[TB] repeats with nothing loaded");
    for (int i = 0; i < 5; i++) applyStimulus(3'b000, 3'b111);
    for (int k = 0; k < 3; k++) begin
      checkValue($sformatf("lit.u%0d.rbuf_rep", k), aR[k], 0);
      checkValue($sformatf("lit.u%0d.repeated", k), int'(rep_a[k]), 5);
      checkValue($sformatf("lit.u%0d.valid_rep", k), int'(valid_v[k]), 0);
    end

    $display("[TB] directed load / present sequences");
    applyStimulus(3'b111, 3'b000);
    checkValue("lit.u0.ready_full", int'(ready_v[0]), 0);
    applyStimulus(3'b110, 3'b001);
    checkValue("lit.u0.rbuf_swap", aR[0], 1);
    checkValue("lit.u0.wbuf_swap", aW[0], 0);
    checkValue("lit.u0.ready_swap", int'(ready_v[0]), 1);
    checkValue("lit.u0.shown", int'(shown_a[0]), 1);
    checkValue("lit.u0.valid", int'(valid_v[0]), 1);
    applyStimulus(3'b110, 3'b000);
    applyStimulus(3'b000, 3'b110);
    checkValue("lit.u1.rbuf_latest", aR[1], 2);
    checkValue("lit.u1.dropped", int'(drop_a[1]), 1);
    checkValue("lit.u1.proto_err", int'(err_v[1]), 1);
    checkValue("lit.u2.rbuf_seq1", aR[2], 1);
    applyStimulus(3'b000, 3'b100);
    checkValue("lit.u2.rbuf_seq2", aR[2], 2);
    applyStimulus(3'b000, 3'b100);
    checkValue("lit.u2.rbuf_seq3", aR[2], 3);
    checkValue("lit.u2.dropped", int'(drop_a[2]), 0);

    $display("[TB] asynchronous reset with two pending frames");
    applyStimulus(3'b100, 3'b000);
    applyStimulus(3'b100, 3'b000);
    checkValue("lit.u2.pending2", aP[2], 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("lit.rst.u2.pending", aP[2], 0);
    checkValue("lit.rst.u2.rbuf", aR[2], 0);
    checkValue("lit.rst.u2.wbuf", aW[2], 1);
    checkValue("lit.rst.u2.ready", int'(ready_v[2]), 1);
    checkValue("lit.rst.u2.shown", int'(shown_a[2]), 0);
    checkValue("lit.rst.u1.err", int'(err_v[1]), 0);
    modelReset();
    releaseReset();

    $display("[TB] same-cycle load and frame end");
    applyStimulus(3'b001, 3'b001);
    checkValue("lit.u0.rbuf_same", aR[0], 1);
    checkValue("lit.u0.wbuf_same", aW[0], 0);
    checkValue("lit.u0.ready_same", int'(ready_v[0]), 1);

    $display("[TB] random pulses");
    for (int n = 0; n < 1200; n++) begin
      logic [2:0] ld, fc;
      for (int k = 0; k < 3; k++) begin
        ld[k] = ($urandom_range(0, 2) == 0);
        fc[k] = ($urandom_range(0, 3) == 0);
      end
      applyStimulus(ld, fc);
      if (n == 600) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        modelReset();
        releaseReset();
      end
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
